button_pio_event_sequencer: RTL and testbench
=============================================

Name: button_pio_event_sequencer

Overview:
- Avalon-MM master that owns the single-bit button PIO slave: it configures it, services its interrupt and debounces press events.
- Enables the PIO interrupt mask after reset. On each irq it reads the edge-capture and data registers, clears the capture, and posts a timestamped event on a valid/ready stream.
- Enforces a debounce holdoff before re-arming, so it sits between the PIO and the fabric or CPU-side event consumer.

Parameters:
- TS_W, 32, width of free-running timestamp counter and evt_timestamp.
- HOLDOFF_CYCLES, 1000, debounce holdoff length in clk cycles (min 1).
- RD_LATENCY, 1, cycles from address presented to avm_readdata valid (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- enable  in  1  1 = service irq; 0 = finish current sequence, then stay IDLE.
- avm_address  out  2  PIO register select (0 data, 2 irq mask, 3 edge capture).
- avm_chipselect  out  1  slave select, asserted with avm_write_n low for writes.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  PIO read data, registered in slave; bit 0 meaningful.
- irq  in  1  PIO interrupt (edge_capture & mask).
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_level  out  1  button level sampled at service time.
- evt_timestamp  out  TS_W  timestamp counter value captured at irq detection.
- busy  out  1  high in any state other than IDLE.
- evt_count  out  16  events accepted by consumer; wraps at 0xFFFF->0.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=INIT; timestamp=0; evt_count=0; evt_valid=0; busy=1.
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - Reset mid-sequence abandons the bus access and any pending event; no drain.
- Timestamp counter increments every cycle and wraps modulo 2^TS_W.
- Bus timing:
  - Write = exactly 1 cycle with chipselect=1, write_n=0.
  - Read = address held; chipselect=0, write_n=1; readdata sampled RD_LATENCY cycles later. A wait counter (0..RD_LATENCY) is used.
  - Outside writes: chipselect=0, write_n=1.
- States:
  - INIT: write addr 2, data 0x1 (unmask) -> IDLE.
  - IDLE: busy=0. If irq && enable, capture timestamp -> RD_CAP. Otherwise stay.
  - RD_CAP: read addr 3. If readdata[0]=0 (spurious/already cleared) -> IDLE with no event. Else -> RD_DAT.
  - RD_DAT: read addr 0; latch evt_level=readdata[0] -> CLR.
  - CLR: write addr 3, data 0 (clears capture) -> POST.
  - POST: evt_valid=1; evt_level and evt_timestamp stable while valid. When evt_valid && evt_ready, evt_valid=0 next cycle, evt_count+=1, holdoff counter loaded with HOLDOFF_CYCLES-1 -> HOLDOFF. No timeout; waits indefinitely for ready.
  - HOLDOFF: counter decrements each cycle; at 0 -> CLR2. irq is ignored in this state.
  - CLR2: write addr 3 (discards bounce edges captured during holdoff) -> IDLE.
- Minimum irq-to-evt_valid latency: 1 (IDLE) + 2·(RD_LATENCY+1) + 1 cycles = 6 for RD_LATENCY=1. Event is visible on the cycle after CLR.
- Edges arriving after the RD_CAP sample and before CLR are merged into the current event; no missed-event flag.
- enable deasserted mid-sequence has no effect until return to IDLE.
- evt_ready is ignored outside POST.
- irq held high continuously (bounce) yields exactly one event per holdoff window.

Test Plan:
- Reset release -> cycle 1 write addr=2, data=0x1, chipselect=1, write_n=0; then busy=0, no further bus activity with irq=0.
- Single press, irq asserted at ts=100, readdata cap=1, data=0, evt_ready=1 -> bus order: read 3, read 0, write 3 data 0. Then evt_valid=1 with evt_timestamp=100, evt_level=0; evt_count=1.
- evt_ready held 0 for 50 cycles in POST -> evt_valid stays 1 with fields unchanged. Ready pulse -> valid drops next cycle; HOLDOFF lasts HOLDOFF_CYCLES=1000 cycles, then write addr 3, then IDLE.
- irq toggling every 7 cycles for 3000 cycles, HOLDOFF_CYCLES=1000 -> ≤3 events, each followed by a CLR2 write.
- Spurious case: irq high but cap read=0 -> no event, back to IDLE, evt_count unchanged. Also run enable=0 with irq=1 -> stays IDLE, no bus access.
- Assert reset during RD_DAT and during POST -> next cycle state=INIT, evt_valid=0, chipselect=0. Separately, check evt_count wraps from 0xFFFF to 0 after 65536 accepted events (force/preload).

Source files
------------

// File: rtl/button_pio_event_sequencer_if.sv
// rtl/button_pio_event_sequencer_if.sv - PIO Avalon-MM bus plus timestamped event stream
interface button_pio_event_sequencer_if #(
  parameter int TS_W = 32
);
  logic [1:0]      avm_address;
  logic            avm_chipselect;
  logic            avm_write_n;
  logic [31:0]     avm_writedata;
  logic [31:0]     avm_readdata;
  logic            irq;
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_level;
  logic [TS_W-1:0] evt_timestamp;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output evt_valid, evt_level, evt_timestamp,
    input  avm_readdata, irq, evt_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  evt_valid, evt_level, evt_timestamp,
    output avm_readdata, irq, evt_ready
  );
endinterface

// File: rtl/button_pio_event_sequencer.sv
// rtl/button_pio_event_sequencer.sv - button PIO master: unmask, service irq, post debounced events
module button_pio_event_sequencer #(
  parameter int TS_W           = 32,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int RD_LATENCY     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  button_pio_event_sequencer_if.master bus,
  output logic                        busy,
  output logic [15:0]                 evt_count
);

  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY);
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD_CAP, S_RD_DAT, S_CLR, S_POST, S_HOLDOFF, S_CLR2
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [TS_W-1:0]   ts, evt_ts;
  logic              level;
  logic [15:0]       count;
  logic              capture_ts, latch_level, accept;
  logic [1:0]        addr, addr_next;
  logic              cs, cs_next, wr_n, wr_n_next;
  logic [31:0]       wdata, wdata_next;
  logic              unused_rd;

  assign unused_rd = ^bus.avm_readdata[31:1];

  always_comb begin
    state_next  = state;
    wait_next   = '0;
    hold_next   = hold_cnt;
    capture_ts  = 1'b0;
    latch_level = 1'b0;
    accept      = 1'b0;
    addr_next   = ADDR_DATA;
    cs_next     = 1'b0;
    wr_n_next   = 1'b1;
    wdata_next  = '0;
    case (state)
      S_INIT: begin
        state_next = S_IDLE;
        addr_next  = ADDR_MASK;
        cs_next    = 1'b1;
        wr_n_next  = 1'b0;
        wdata_next = 32'h1;
      end
      S_IDLE: begin
        if (bus.irq && enable) begin
          state_next = S_RD_CAP;
          capture_ts = 1'b1;
        end
      end
      S_RD_CAP: begin
        if (wait_cnt == WAIT_LAST) state_next = bus.avm_readdata[0] ? S_RD_DAT : S_IDLE;
        else wait_next = wait_cnt + WAIT_W'(1);
      end
      S_RD_DAT: begin
        if (wait_cnt == WAIT_LAST) begin
          latch_level = 1'b1;
          state_next  = S_CLR;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      S_CLR: state_next = S_POST;
      S_POST: begin
        if (bus.evt_ready) begin
          accept     = 1'b1;
          hold_next  = HOLD_LOAD;
          state_next = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt == '0) state_next = S_CLR2;
        else hold_next = hold_cnt - HOLD_W'(1);
      end
      S_CLR2: state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
    // Bus outputs are registered from the next state so the access lines up with its state
    case (state_next)
      S_RD_CAP: addr_next = ADDR_CAP;
      S_CLR, S_CLR2: begin
        addr_next  = ADDR_CAP;
        cs_next    = 1'b1;
        wr_n_next  = 1'b0;
        wdata_next = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      wait_cnt <= '0;
      hold_cnt <= '0;
      ts       <= '0;
      evt_ts   <= '0;
      level    <= 1'b0;
      count    <= '0;
      addr     <= ADDR_DATA;
      cs       <= 1'b0;
      wr_n     <= 1'b1;
      wdata    <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      hold_cnt <= hold_next;
      ts       <= ts + TS_W'(1);
      addr     <= addr_next;
      cs       <= cs_next;
      wr_n     <= wr_n_next;
      wdata    <= wdata_next;
      if (capture_ts) evt_ts <= ts;
      if (latch_level) level <= bus.avm_readdata[0];
      if (accept) count <= count + 16'd1;
    end
  end

  assign bus.avm_address    = addr;
  assign bus.avm_chipselect = cs;
  assign bus.avm_write_n    = wr_n;
  assign bus.avm_writedata  = wdata;
  assign bus.evt_valid      = (state == S_POST);
  assign bus.evt_level      = level;
  assign bus.evt_timestamp  = evt_ts;
  assign busy               = (state != S_IDLE);
  assign evt_count          = count;

endmodule

// File: tb/tb_button_pio_event_sequencer.sv
// tb/tb_button_pio_event_sequencer.sv - self-checking bench with a behavioural button PIO model
module tb_button_pio_event_sequencer;
  localparam int TS_W    = 32;
  localparam int HOLDOFF = 1000;
  localparam int RDL     = 1;
  localparam int LAT     = 1 + 2 * (RDL + 1) + 1;

  logic clk = 1'b0;
  logic reset, enable;
  logic busy;
  logic [15:0] evt_count;

  button_pio_event_sequencer_if #(.TS_W(TS_W)) bus ();

  button_pio_event_sequencer #(.TS_W(TS_W), .HOLDOFF_CYCLES(HOLDOFF), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus), .busy(busy), .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int hs_cnt = 0;
  int wr_cnt = 0;
  int wr3_cnt = 0;
  logic btn, irq_force;
  logic btn_prev, pio_cap, pio_mask;
  logic [TS_W-1:0] tb_ts;

  // Button PIO: registered reads, edge capture cleared by write, irq = capture & mask
  always @(posedge clk) begin
    if (reset) begin
      pio_cap <= 1'b0;
      pio_mask <= 1'b0;
      bus.avm_readdata <= '0;
      tb_ts <= '0;
    end else begin
      tb_ts <= tb_ts + 1;
      case (bus.avm_address)
        2'd0:    bus.avm_readdata <= {31'd0, btn};
        2'd2:    bus.avm_readdata <= {31'd0, pio_mask};
        2'd3:    bus.avm_readdata <= {31'd0, pio_cap};
        default: bus.avm_readdata <= '0;
      endcase
      if (btn != btn_prev) pio_cap <= 1'b1;
      else if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3) pio_cap <= 1'b0;
      if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2) pio_mask <= bus.avm_writedata[0];
      if (bus.evt_valid && bus.evt_ready) hs_cnt <= hs_cnt + 1;
      if (bus.avm_chipselect && !bus.avm_write_n) begin
        wr_cnt <= wr_cnt + 1;
        if (bus.avm_address == 2'd3) wr3_cnt <= wr3_cnt + 1;
      end
    end
    btn_prev <= btn;
  end

  assign bus.irq = (pio_cap & pio_mask) | irq_force;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout busy=%0b after %0d cycles", busy, n); end
  endtask

  task automatic wait_valid(input int max_cycles, output int lat);
    lat = 0;
    while (bus.evt_valid !== 1'b1 && lat < max_cycles) begin tick(); lat++; end
    checks++;
    if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL valid_timeout valid=%0b after %0d cycles", bus.evt_valid, lat); end
  endtask

  task automatic test_reset();
    logic bad;
    repeat (3) tick();
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.evt_valid); end
    checks++; if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1) begin errors++; $display("FAIL reset_strobes cs=%0b wn=%0b want 0/1", bus.avm_chipselect, bus.avm_write_n); end
    checks++; if (bus.avm_address !== 2'd0 || bus.avm_writedata !== 32'd0) begin errors++; $display("FAIL reset_addr_data addr=%0d wd=%h want 0/0", bus.avm_address, bus.avm_writedata); end
    checks++; if (busy !== 1'b1 || evt_count !== 16'd0) begin errors++; $display("FAIL reset_busy_count busy=%0b cnt=%0d want 1/0", busy, evt_count); end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.avm_chipselect !== 1'b1 || bus.avm_write_n !== 1'b0 || bus.avm_address !== 2'd2 || bus.avm_writedata !== 32'h1) begin
      errors++; $display("FAIL init_write cs=%0b wn=%0b addr=%0d wd=%h want 1/0/2/1", bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata);
    end
    tick();
    checks++; if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_init cs=%0b wn=%0b busy=%0b want 0/1/0", bus.avm_chipselect, bus.avm_write_n, busy); end
    bad = 1'b0;
    repeat (20) begin tick(); if (busy !== 1'b0 || bus.avm_chipselect !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL idle_quiet activity seen with irq=0, want none"); end
  endtask

  task automatic test_single_press();
    logic [TS_W-1:0] t0;
    int n;
    wait_idle(50);
    bus.evt_ready = 1'b1;
    n = 0;
    while (tb_ts != 99 && n < 200) begin tick(); n++; end
    btn = 1'b1; tick(); btn = 1'b0;
    t0 = tb_ts;
    checks++; if (t0 !== 100) begin errors++; $display("FAIL press_ts_setup got %0d want 100", t0); end
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (k <= RDL + 1) begin
        if (bus.avm_address !== 2'd3 || bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1) begin errors++; $display("FAIL rd_cap_bus k=%0d addr=%0d cs=%0b want 3/0", k, bus.avm_address, bus.avm_chipselect); end
      end else if (k <= 2 * (RDL + 1)) begin
        if (bus.avm_address !== 2'd0 || bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1) begin errors++; $display("FAIL rd_dat_bus k=%0d addr=%0d cs=%0b want 0/0", k, bus.avm_address, bus.avm_chipselect); end
      end else if (k == LAT - 1) begin
        if (bus.avm_address !== 2'd3 || bus.avm_chipselect !== 1'b1 || bus.avm_write_n !== 1'b0 || bus.avm_writedata !== 32'd0) begin errors++; $display("FAIL clr_bus addr=%0d cs=%0b wn=%0b want 3/1/0", bus.avm_address, bus.avm_chipselect, bus.avm_write_n); end
      end else begin
        if (bus.evt_valid !== 1'b1 || bus.evt_timestamp !== t0 || bus.evt_level !== 1'b0) begin errors++; $display("FAIL press_event valid=%0b ts=%0d lvl=%0b want 1/%0d/0", bus.evt_valid, bus.evt_timestamp, bus.evt_level, t0); end
      end
    end
    tick();
    exp_count++;
    checks++; if (bus.evt_valid !== 1'b0 || evt_count !== 16'(exp_count)) begin errors++; $display("FAIL press_accept valid=%0b cnt=%0d want 0/%0d", bus.evt_valid, evt_count, exp_count); end
    n = 0;
    while (!(bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0) && n < HOLDOFF + 100) begin tick(); n++; end
    checks++; if (n != HOLDOFF) begin errors++; $display("FAIL holdoff_len got %0d want %0d", n, HOLDOFF); end
    checks++; if (bus.avm_address !== 2'd3 || bus.avm_writedata !== 32'd0) begin errors++; $display("FAIL clr2_write addr=%0d wd=%h want 3/0", bus.avm_address, bus.avm_writedata); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL after_clr2 busy=%0b want 0", busy); end
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [TS_W-1:0] t0;
    int lat, c0;
    logic bad;
    wait_idle(50);
    repeat ($urandom_range(3, 20)) tick();
    btn = 1'b1; tick(); t0 = tb_ts;
    wait_valid(20, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL stall_latency got %0d want %0d", lat, LAT); end
    bad = 1'b0;
    repeat (50) begin
      tick();
      if (bus.evt_valid !== 1'b1 || bus.evt_timestamp !== t0 || bus.evt_level !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL stall_hold valid=%0b ts=%0d lvl=%0b want 1/%0d/1", bus.evt_valid, bus.evt_timestamp, bus.evt_level, t0); end
    bus.evt_ready = 1'b1; tick(); bus.evt_ready = 1'b0;
    exp_count++;
    checks++; if (bus.evt_valid !== 1'b0 || evt_count !== 16'(exp_count)) begin errors++; $display("FAIL stall_accept valid=%0b cnt=%0d want 0/%0d", bus.evt_valid, evt_count, exp_count); end
    repeat (100) tick();
    btn = 1'b0;
    c0 = hs_cnt;
    wait_idle(HOLDOFF + 50);
    bad = 1'b0;
    repeat (30) begin tick(); if (busy !== 1'b0) bad = 1'b1; end
    checks++; if (bad || hs_cnt != c0) begin errors++; $display("FAIL holdoff_discard events=%0d want %0d", hs_cnt, c0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic lvl;
      logic [TS_W-1:0] t0;
      int lat;
      wait_idle(HOLDOFF + 50);
      enable = 1'b1;
      repeat ($urandom_range(2, 15)) tick();
      lvl = 1'($urandom_range(0, 1));
      btn = ~btn; tick(); t0 = tb_ts;
      if (btn !== lvl) btn = lvl;
      wait_valid(20, lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand_latency it=%0d got %0d want %0d", it, lat, LAT); end
      checks++; if (bus.evt_timestamp !== t0) begin errors++; $display("FAIL rand_ts it=%0d got %0d want %0d", it, bus.evt_timestamp, t0); end
      checks++; if (bus.evt_level !== lvl) begin errors++; $display("FAIL rand_level it=%0d got %0b want %0b", it, bus.evt_level, lvl); end
      enable = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 10)) tick();
      bus.evt_ready = 1'b1; tick(); bus.evt_ready = 1'b0;
      exp_count++;
      checks++; if (bus.evt_valid !== 1'b0 || evt_count !== 16'(exp_count)) begin errors++; $display("FAIL rand_accept it=%0d valid=%0b cnt=%0d want 0/%0d", it, bus.evt_valid, evt_count, exp_count); end
    end
    wait_idle(HOLDOFF + 50);
    enable = 1'b1;
  endtask

  task automatic test_bounce();
    int h0, w0, ev, n;
    wait_idle(50);
    bus.evt_ready = 1'b1;
    h0 = hs_cnt; w0 = wr3_cnt;
    for (int i = 0; i < 3000; i++) begin
      if (i % 7 == 0) btn = ~btn;
      tick();
    end
    ev = hs_cnt - h0;
    checks++; if (ev < 1 || ev > 3) begin errors++; $display("FAIL bounce_events got %0d want 1..3", ev); end
    n = 0;
    while (!(busy === 1'b0 && bus.irq === 1'b0) && n < 2500) begin tick(); n++; end
    checks++; if (busy !== 1'b0 || bus.irq !== 1'b0) begin errors++; $display("FAIL bounce_drain busy=%0b irq=%0b want 0/0", busy, bus.irq); end
    ev = hs_cnt - h0;
    exp_count += ev;
    checks++; if (wr3_cnt - w0 != 2 * ev) begin errors++; $display("FAIL bounce_clr_writes got %0d want %0d", wr3_cnt - w0, 2 * ev); end
    checks++; if (evt_count !== 16'(exp_count)) begin errors++; $display("FAIL bounce_count got %0d want %0d", evt_count, exp_count); end
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_spurious();
    int w0;
    logic bad;
    wait_idle(50);
    w0 = wr_cnt;
    irq_force = 1'b1; tick(); irq_force = 1'b0;
    checks++; if (busy !== 1'b1 || bus.avm_address !== 2'd3) begin errors++; $display("FAIL spur_read busy=%0b addr=%0d want 1/3", busy, bus.avm_address); end
    repeat (RDL + 1) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_return busy=%0b want 0", busy); end
    bad = 1'b0;
    repeat (20) begin tick(); if (busy !== 1'b0 || bus.evt_valid !== 1'b0) bad = 1'b1; end
    checks++; if (bad || wr_cnt != w0 || evt_count !== 16'(exp_count)) begin errors++; $display("FAIL spur_no_event writes=%0d cnt=%0d want %0d/%0d", wr_cnt, evt_count, w0, exp_count); end
    enable = 1'b0; irq_force = 1'b1;
    bad = 1'b0;
    repeat (30) begin tick(); if (busy !== 1'b0 || bus.avm_chipselect !== 1'b0 || bus.avm_address !== 2'd0) bad = 1'b1; end
    checks++; if (bad || wr_cnt != w0) begin errors++; $display("FAIL disabled_idle busy=%0b addr=%0d want 0/0", busy, bus.avm_address); end
    irq_force = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic bad;
    wait_idle(50);
    btn = ~btn;
    repeat (4) tick();
    checks++; if (busy !== 1'b1 || bus.avm_address !== 2'd0) begin errors++; $display("FAIL mid_rd_dat busy=%0b addr=%0d want 1/0", busy, bus.avm_address); end
    reset = 1'b1; tick();
    checks++; if (bus.evt_valid !== 1'b0 || bus.avm_chipselect !== 1'b0 || busy !== 1'b1 || evt_count !== 16'd0) begin errors++; $display("FAIL rst_rd_dat valid=%0b cs=%0b busy=%0b cnt=%0d want 0/0/1/0", bus.evt_valid, bus.avm_chipselect, busy, evt_count); end
    reset = 1'b0; exp_count = 0;
    wait_idle(10);
    repeat (5) tick();
    btn = ~btn; tick();
    wait_valid(20, lat);
    reset = 1'b1; tick();
    checks++; if (bus.evt_valid !== 1'b0 || bus.avm_chipselect !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_post valid=%0b cs=%0b busy=%0b want 0/0/1", bus.evt_valid, bus.avm_chipselect, busy); end
    reset = 1'b0;
    wait_idle(10);
    bad = 1'b0;
    repeat (20) begin tick(); if (busy !== 1'b0 || bus.evt_valid !== 1'b0) bad = 1'b1; end
    checks++; if (bad || evt_count !== 16'(exp_count)) begin errors++; $display("FAIL rst_after cnt=%0d want %0d", evt_count, exp_count); end
  endtask

  task automatic test_wrap();
    int lat;
    wait_idle(50);
    force dut.count = 16'hFFFF;
    tick();
    release dut.count;
    exp_count = 16'hFFFF;
    tick();
    bus.evt_ready = 1'b1;
    btn = ~btn; tick();
    wait_valid(20, lat);
    tick();
    bus.evt_ready = 1'b0;
    exp_count = (exp_count + 1) % 65536;
    checks++; if (evt_count !== 16'(exp_count)) begin errors++; $display("FAIL count_wrap got %0h want %0h", evt_count, exp_count); end
    wait_idle(HOLDOFF + 50);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    btn = 1'b0;
    irq_force = 1'b0;
    bus.evt_ready = 1'b0;
    test_reset();
    test_single_press();
    test_stall();
    test_random();
    test_bounce();
    test_spurious();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
